// File: rtl/vmul_issue_ctrl_pkg.sv
// Shared types and widths for the vector multiplier issue controller.
//   opcode_e    : multiplier operation select
//   precision_e : lane width select (PILLEGAL is accepted but flagged)
//   vmul_res_t  : one result FIFO entry {result, tag, err}
package vmul_issue_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RES_TAG_W = 4;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULH  = 2'b01,
        OP_MULHU = 2'b10,
        OP_MULSU = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        P8       = 2'b00,
        P16      = 2'b01,
        P32      = 2'b10,
        PILLEGAL = 2'b11
    } precision_e;

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic [RES_TAG_W-1:0] tag;
        logic                 err;
    } vmul_res_t;

endpackage

// File: rtl/vmul_issue_ctrl_if.sv
// Bus bundle between issue stage, multiplier pipeline and result consumer.
//   in_*   : issue request (valid/ready)
//   mul_*  : operand/opcode/precision to the multiplier, result back from it
//   out_*  : buffered result head (valid/ready)
//   busy   : any op in flight or buffered
// slave is the controller side, master the surrounding environment.
interface vmul_issue_ctrl_if
    import vmul_issue_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = RES_TAG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_opa;
    logic [DATA_W-1:0] in_opb;
    logic [1:0]        in_opcode;
    logic [1:0]        in_precision;
    logic [TAG_W-1:0]  in_tag;

    logic [DATA_W-1:0] mul_opa_o;
    logic [DATA_W-1:0] mul_opb_o;
    logic [1:0]        mul_opcode_o;
    logic [1:0]        mul_precision_o;
    logic [DATA_W-1:0] mul_result_i;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic              busy;

    modport slave (
        input  in_valid, in_opa, in_opb, in_opcode, in_precision, in_tag,
        output in_ready,
        output mul_opa_o, mul_opb_o, mul_opcode_o, mul_precision_o,
        input  mul_result_i,
        output out_valid, out_result, out_tag, out_err,
        input  out_ready,
        output busy
    );

    modport master (
        output in_valid, in_opa, in_opb, in_opcode, in_precision, in_tag,
        input  in_ready,
        input  mul_opa_o, mul_opb_o, mul_opcode_o, mul_precision_o,
        output mul_result_i,
        input  out_valid, out_result, out_tag, out_err,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/vmul_issue_ctrl_result_fifo.sv
// Circular result buffer.
//   push/push_data : write one entry at the tail
//   pop            : drop the head (ignored when empty)
//   head           : current head entry
//   count/full/empty : occupancy
module vmul_issue_ctrl_result_fifo
    import vmul_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter type         T     = vmul_res_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_eff = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= ptr_inc(wr_ptr);
            if (pop_eff) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop_eff);
        end
    end

    // Storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    push_at_full_a: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop));

endmodule

// File: rtl/vmul_issue_ctrl.sv
// Valid/ready front-end and result buffer around a fixed-latency vector multiplier.
//   clk, rst : clock, async active-low reset
//   bus      : issue, multiplier and result signals (see vmul_issue_ctrl_if)
// Issue is credit based: an op is only accepted when a FIFO slot is guaranteed
// for it, so the result FIFO can never overflow.
module vmul_issue_ctrl
    import vmul_issue_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 5,
    parameter int unsigned TAG_W      = RES_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    vmul_issue_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             ready;
    logic             accept;
    logic             illegal;
    logic             pass;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] credits;
    logic [LATENCY-1:0] sh_valid;
    logic [LATENCY-1:0] sh_err;
    logic [TAG_W-1:0]   sh_tag [LATENCY];
    vmul_res_t        push_data;
    vmul_res_t        head;

    // Credits from registered state only; out_ready/in_valid never reach in_ready
    assign credits      = CNT_W'(FIFO_DEPTH) - fifo_count - inflight;
    assign ready        = rst & ~fifo_full & (credits != '0);
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid & ready;
    assign illegal      = (bus.in_precision == PILLEGAL);
    assign pass         = accept & ~illegal;

    // Operand gating: multiplier inputs stay quiet unless a legal op is issued
    always_comb begin
        bus.mul_opa_o       = '0;
        bus.mul_opb_o       = '0;
        bus.mul_opcode_o    = OP_MUL;
        bus.mul_precision_o = P8;
        if (pass) begin
            bus.mul_opa_o       = bus.in_opa;
            bus.mul_opb_o       = bus.in_opb;
            bus.mul_opcode_o    = bus.in_opcode;
            bus.mul_precision_o = bus.in_precision;
        end
    end

    // Shadow pipe tracks which multiplier output cycles carry a real result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_valid <= '0;
            sh_err   <= '0;
            inflight <= '0;
            for (int i = 0; i < LATENCY; i++) sh_tag[i] <= '0;
        end else begin
            sh_valid[0] <= accept;
            sh_err[0]   <= illegal;
            sh_tag[0]   <= bus.in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_err[i]   <= sh_err[i-1];
                sh_tag[i]   <= sh_tag[i-1];
            end
            inflight <= inflight + CNT_W'(accept) - CNT_W'(sh_valid[LATENCY-1]);
        end
    end

    // Capture at the end of the shadow pipe; illegal ops carry a zero result
    assign push             = sh_valid[LATENCY-1];
    assign push_data.result = sh_err[LATENCY-1] ? '0 : bus.mul_result_i;
    assign push_data.tag    = RES_TAG_W'(sh_tag[LATENCY-1]);
    assign push_data.err    = sh_err[LATENCY-1];

    assign pop = ~fifo_empty & bus.out_ready;

    vmul_issue_ctrl_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (vmul_res_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head is masked while empty so stale storage never shows on the bus
    assign bus.out_valid  = ~fifo_empty;
    assign bus.out_result = fifo_empty ? '0 : head.result;
    assign bus.out_tag    = fifo_empty ? '0 : TAG_W'(head.tag);
    assign bus.out_err    = ~fifo_empty & head.err;
    assign bus.busy       = (inflight != '0) | (fifo_count != '0);

    credit_underflow_a: assert property (@(posedge clk) disable iff (!rst)
        (32'(fifo_count) + 32'(inflight)) <= 32'(FIFO_DEPTH));

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Self-checking bench for vmul_issue_ctrl: a fixed-latency multiplier stub
// drives mul_result_i, and a queue-based model predicts handshakes and results.
module tb_vmul_issue_ctrl;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 5;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   dut_acc;
    int   nacc;
    exp_t sb[$];
    logic [31:0] mpipe [LAT];

    vmul_issue_ctrl_if #(.TAG_W(4)) bus ();

    vmul_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-wise multiply straight from the ISA definition
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic [1:0] prec);
        int w;
        logic [31:0] r, la, lb, mask;
        logic signed [65:0] xa, xb, p, sh;
        if (prec == 2'b11) return 32'hDEADBEEF;
        w    = 8 << prec;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r    = '0;
        for (int l = 0; l < 32 / w; l++) begin
            la = (a >> (l * w)) & mask;
            lb = (b >> (l * w)) & mask;
            xa = 66'(la);
            xb = 66'(lb);
            if ((op == 2'b01 || op == 2'b11) && la[w-1]) xa = xa - (66'sd1 <<< w);
            if (op == 2'b01 && lb[w-1]) xb = xb - (66'sd1 <<< w);
            p  = xa * xb;
            sh = (op == 2'b00) ? p : (p >>> w);
            r  = r | ((32'(sh) & mask) << (l * w));
        end
        return r;
    endfunction

    // Multiplier stub: result appears LAT cycles after operands are presented
    always @(posedge clk) begin
        mpipe[0] <= ref_mul(bus.mul_opa_o, bus.mul_opb_o, bus.mul_opcode_o, bus.mul_precision_o);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_result_i = mpipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [1:0] prec, input logic [3:0] tag);
        bus.in_valid     = v;
        bus.in_opa       = a;
        bus.in_opb       = b;
        bus.in_opcode    = op;
        bus.in_precision = prec;
        bus.in_tag       = tag;
    endtask

    // One clock: check against the model mid-cycle, update model, advance
    task automatic step();
        logic exp_ready, exp_valid, acc, legal;
        exp_t e;
        #1;
        exp_ready = (sb.size() < DEPTH);
        exp_valid = (sb.size() != 0) && (sb[0].due <= cyc);
        chk("in_ready",  32'(bus.in_ready),  32'(exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("busy",      32'(bus.busy),      32'(sb.size() != 0));
        if (exp_valid) begin
            chk("out_result", bus.out_result,   sb[0].res);
            chk("out_tag",    32'(bus.out_tag), 32'(sb[0].tag));
            chk("out_err",    32'(bus.out_err), 32'(sb[0].err));
        end
        acc   = bus.in_valid & exp_ready;
        legal = (bus.in_precision != 2'b11);
        chk("mul_opa",  bus.mul_opa_o, (acc && legal) ? bus.in_opa : 32'd0);
        chk("mul_opb",  bus.mul_opb_o, (acc && legal) ? bus.in_opb : 32'd0);
        chk("mul_op",   32'(bus.mul_opcode_o),    (acc && legal) ? 32'(bus.in_opcode) : 32'd0);
        chk("mul_prec", 32'(bus.mul_precision_o), (acc && legal) ? 32'(bus.in_precision) : 32'd0);
        if (bus.in_valid && bus.in_ready) dut_acc++;
        if (exp_valid && bus.out_ready) void'(sb.pop_front());
        if (acc) begin
            e.res = legal ? ref_mul(bus.in_opa, bus.in_opb, bus.in_opcode, bus.in_precision) : 32'd0;
            e.tag = bus.in_tag;
            e.err = ~legal;
            e.due = cyc + LAT + 1;
            sb.push_back(e);
            nacc++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        dut_acc  = 0;
        nacc     = 0;
        rst      = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready",   32'(bus.in_ready),  32'd0);
        chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_busy",       32'(bus.busy),      32'd0);
        chk("rst_out_result", bus.out_result,     32'd0);
        chk("rst_out_tag",    32'(bus.out_tag),   32'd0);
        chk("rst_out_err",    32'(bus.out_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1. Single op latency and value
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h7, 32'h6, 2'b00, 2'b10, 4'd3);
        step();
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        repeat (3) step();
        #1;
        chk("t1_valid",  32'(bus.out_valid), 32'd1);
        chk("t1_result", bus.out_result,     32'h0000_002A);
        chk("t1_tag",    32'(bus.out_tag),   32'd3);
        chk("t1_err",    32'(bus.out_err),   32'd0);
        drain();

        // 2. Lane behaviour
        drive(1'b1, 32'h0A0B0C0D, 32'h02020202, 2'b00, 2'b00, 4'd1);
        step();
        drive(1'b1, 32'hFFFF0002, 32'hFFFF0003, 2'b10, 2'b01, 4'd2);
        step();
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        repeat (2) step();
        #1;
        chk("t2_p8", bus.out_result, 32'h1416181A);
        step();
        #1;
        chk("t2_p16hu", bus.out_result, 32'hFFFE0000);
        drain();

        // 3. Backpressure fills exactly DEPTH credits
        bus.out_ready = 1'b0;
        nacc = 0;
        acc0 = dut_acc;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, $urandom, $urandom, 2'b00, 2'b10, 4'(nacc));
            step();
        end
        chk("t3_accepts", 32'(dut_acc - acc0), 32'd5);
        #1;
        chk("t3_stalled", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        bus.out_ready = 1'b1;
        step();
        #1;
        chk("t3_ready_after_pop", 32'(bus.in_ready), 32'd1);
        drain();

        // 4. Throughput with random legal ops
        acc0 = dut_acc;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 2)), 4'($urandom));
            step();
        end
        chk("t4_accepts", 32'(dut_acc - acc0), 32'd100);
        drain();

        // 5. Illegal precision
        drive(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 2'b11, 4'd9);
        step();
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        repeat (3) step();
        #1;
        chk("t5_result", bus.out_result,     32'd0);
        chk("t5_err",    32'(bus.out_err),   32'd1);
        chk("t5_tag",    32'(bus.out_tag),   32'd9);
        drain();

        // 6. Reset with 3 in flight and 2 buffered
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, $urandom, 2'b00, 2'b10, 4'(i + 10));
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 4'd0);
        rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_busy",      32'(bus.busy),      32'd0);
        chk("t6_rst_in_ready",  32'(bus.in_ready),  32'd0);
        sb.delete();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        repeat (8) step();

        // Mixed random traffic including illegal precision and backpressure
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom));
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
